// File: rtl/minimac_rxfifo_ctl_pkg.sv
// Shared types and constants for the minimac RX FIFO drain controller.
package minimac_pkg;

   typedef enum logic [2:0] {
      ST_SYNC    = 3'd0,
      ST_WAIT    = 3'd1,
      ST_RECV    = 3'd2,
      ST_DISCARD = 3'd3,
      ST_DONE    = 3'd4
   } rx_state_e;

   localparam int EOF_BIT       = 8;
   localparam int MAX_BYTES_DEF = 1536;
   localparam int LEN_W         = 11;

endpackage

// File: rtl/minimac_rxfifo_ctl_if.sv
// FIFO read handshake and slot-buffer write bus of the RX drain controller.
interface minimac_rxfifo_ctl_if
   import minimac_pkg::*;
#(
   parameter int AW = 9
);
   logic               fifo_empty;
   logic [EOF_BIT:0]   fifo_data;
   logic               fifo_re;
   logic               mem_we;
   logic [AW-1:0]      mem_adr;
   logic [31:0]        mem_dat;
   logic [3:0]         mem_be;

   modport master (
      input  fifo_empty, fifo_data,
      output fifo_re, mem_we, mem_adr, mem_dat, mem_be
   );

   modport slave (
      output fifo_empty, fifo_data,
      input  fifo_re, mem_we, mem_adr, mem_dat, mem_be
   );
endinterface

// File: rtl/minimac_rx_packer.sv
// Byte lane packer: gathers bytes big-endian into a word and issues one registered
// slot-buffer write on lane 3 or on the last byte of a frame.
module minimac_rx_packer #(
   parameter int AW = 9
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clear_i,
   input  logic          push_i,
   input  logic [7:0]    byte_i,
   input  logic [1:0]    lane_i,
   input  logic          last_i,
   input  logic [AW-1:0] adr_i,
   output logic          mem_we_o,
   output logic [AW-1:0] mem_adr_o,
   output logic [31:0]   mem_dat_o,
   output logic [3:0]    mem_be_o
);
   logic [31:0]   acc_dat_q, acc_dat_d, merged_dat;
   logic [3:0]    acc_be_q, acc_be_d, merged_be;
   logic          we_q, we_d;
   logic [AW-1:0] adr_q, adr_d;
   logic [31:0]   dat_q, dat_d;
   logic [3:0]    be_q, be_d;

   assign merged_dat = acc_dat_q | ({byte_i, 24'h0} >> {lane_i, 3'b000});
   assign merged_be  = acc_be_q | (4'b1000 >> lane_i);

   // NOTE: every variable gets a default before any branch, so no path leaves one
   // unassigned and no latch is inferred.
   always_comb begin
      acc_dat_d = acc_dat_q;
      acc_be_d  = acc_be_q;
      we_d      = 1'b0;
      adr_d     = adr_q;
      dat_d     = dat_q;
      be_d      = be_q;
      if (push_i) begin
         if (lane_i == 2'd3 || last_i) begin
            we_d      = 1'b1;
            adr_d     = adr_i;
            dat_d     = merged_dat;
            be_d      = merged_be;
            acc_dat_d = '0;
            acc_be_d  = '0;
         end else begin
            acc_dat_d = merged_dat;
            acc_be_d  = merged_be;
         end
      end
      if (clear_i) begin
         acc_dat_d = '0;
         acc_be_d  = '0;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_dat_q <= '0;
         acc_be_q  <= '0;
         we_q      <= 1'b0;
         adr_q     <= '0;
         dat_q     <= '0;
         be_q      <= '0;
      end else begin
         acc_dat_q <= acc_dat_d;
         acc_be_q  <= acc_be_d;
         we_q      <= we_d;
         adr_q     <= adr_d;
         dat_q     <= dat_d;
         be_q      <= be_d;
      end
   end

   assign mem_we_o  = we_q;
   assign mem_adr_o = adr_q;
   assign mem_dat_o = dat_q;
   assign mem_be_o  = be_q;

endmodule

// File: rtl/minimac_rxfifo_ctl.sv
// RX FIFO drain controller: frames bytes into a host-armed slot, drops or truncates.
// Define MINIMAC_RXCTL_STATS_EN to build the saturating drop/overflow counter.
module minimac_rxfifo_ctl
   import minimac_pkg::*;
#(
   parameter int AW        = 9,
   parameter int MAX_BYTES = MAX_BYTES_DEF
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst_n,
   minimac_rxfifo_ctl_if.master fifo_mem,
   input  logic                 slot_arm,
   output logic                 slot_armed,
   input  logic                 ctl_flush,
   output logic                 done,
   output logic [LEN_W-1:0]     done_len,
   output logic                 overflow,
   output logic [15:0]          drop_count
);
   localparam int CNT_W = (AW + 2 > LEN_W) ? AW + 2 : LEN_W;

   rx_state_e        state_q, state_d;
   logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
   logic             slot_armed_q, slot_armed_d;
   logic             ovf_q, ovf_d;
   logic             last_eof_q;
   logic             pop, eof, eof_seen, at_max;
   logic             pack_push, pack_clear;

   assign pop      = !fifo_mem.fifo_empty && (state_q inside {ST_SYNC, ST_RECV, ST_DISCARD});
   assign eof      = fifo_mem.fifo_data[EOF_BIT];
   assign eof_seen = pop ? eof : last_eof_q;
   assign at_max   = (byte_cnt_q == CNT_W'(MAX_BYTES));
   assign fifo_mem.fifo_re = pop;

   always_comb begin
      state_d    = state_q;
      byte_cnt_d = byte_cnt_q;
      ovf_d      = 1'b0;
      pack_push  = 1'b0;
      unique case (state_q)
         ST_SYNC: begin
            if (pop && eof) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            byte_cnt_d = '0;
            if (!fifo_mem.fifo_empty) state_d = slot_armed_q ? ST_RECV : ST_DISCARD;
         end
         ST_RECV: begin
            if (pop) begin
               if (at_max) begin
                  // An EOF one past the limit is also too long, but the frame has
                  // ended, so there is nothing left to discard.
                  ovf_d   = 1'b1;
                  state_d = eof ? ST_WAIT : ST_DISCARD;
               end else begin
                  pack_push  = 1'b1;
                  byte_cnt_d = byte_cnt_q + 1'b1;
                  if (eof) state_d = ST_DONE;
               end
            end
         end
         ST_DISCARD: begin
            if (pop && eof) state_d = ST_WAIT;
         end
         ST_DONE: begin
            state_d = ST_WAIT;
         end
         default: begin
            state_d = ST_SYNC;
         end
      endcase
      if (ctl_flush) begin
         state_d    = eof_seen ? ST_WAIT : ST_SYNC;
         byte_cnt_d = '0;
         ovf_d      = 1'b0;
         pack_push  = 1'b0;
      end
   end

   always_comb begin
      slot_armed_d = slot_armed_q;
      if (ctl_flush)              slot_armed_d = 1'b0;
      else if (slot_arm)          slot_armed_d = 1'b1;
      else if (state_q == ST_DONE) slot_armed_d = 1'b0;
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q      <= ST_SYNC;
         byte_cnt_q   <= '0;
         slot_armed_q <= 1'b0;
         ovf_q        <= 1'b0;
         last_eof_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         byte_cnt_q   <= byte_cnt_d;
         slot_armed_q <= slot_armed_d;
         ovf_q        <= ovf_d;
         if (pop) last_eof_q <= eof;
      end
   end

   assign pack_clear = ctl_flush || ovf_d;

   minimac_rx_packer #(.AW(AW)) u_packer (
      .clk       (sys_clk),
      .rst_n     (sys_rst_n),
      .clear_i   (pack_clear),
      .push_i    (pack_push),
      .byte_i    (fifo_mem.fifo_data[7:0]),
      .lane_i    (byte_cnt_q[1:0]),
      .last_i    (eof),
      .adr_i     (byte_cnt_q[AW+1:2]),
      .mem_we_o  (fifo_mem.mem_we),
      .mem_adr_o (fifo_mem.mem_adr),
      .mem_dat_o (fifo_mem.mem_dat),
      .mem_be_o  (fifo_mem.mem_be)
   );

   assign slot_armed = slot_armed_q;
   assign done       = (state_q == ST_DONE) && !ctl_flush;
   assign done_len   = done ? byte_cnt_q[LEN_W-1:0] : '0;
   assign overflow   = ovf_q;

`ifdef MINIMAC_RXCTL_STATS_EN
   logic [15:0] drop_cnt_q;
   logic        drop_evt;

   assign drop_evt = (state_q == ST_WAIT && !fifo_mem.fifo_empty && !slot_armed_q && !ctl_flush)
                     || ovf_d;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n)                           drop_cnt_q <= '0;
      else if (ctl_flush)                       drop_cnt_q <= '0;
      else if (drop_evt && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
   end

   assign drop_count = drop_cnt_q;
`else
   assign drop_count = '0;
`endif

endmodule
